spike_event_receiver: RTL

- Consumer end of the serialized spike-event stream (spike_valid/spike_id/spike_ready) produced by the interconnect arbiter.
- Buffers incoming neuron IDs in a small FIFO, decodes each ID into a one-hot bit, and accumulates a per-timestep spike bitmap.
- On a timestep tick, finishes draining the current frame's events, then publishes the bitmap downstream (next layer / synapse fetch) over a valid/ready handshake.

---
 rtl/spike_event_receiver_if.sv | 54 +++++
 rtl/spike_event_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_receiver_if.sv
// -----------------------------------------------------------------------------
// spike_event_receiver_if
//
// Bundles the two handshake buses around the spike event receiver:
//   - the serialized spike-event stream from the interconnect arbiter
//     (spike_valid / spike_id / spike_ready) plus the end-of-timestep tick,
//   - the published per-timestep bitmap towards the next layer
//     (frame_valid / frame_spikes / frame_ready) plus the sticky tick_overrun.
//
// Modports:
//   master : environment view (drives events, tick and frame_ready)
//   slave  : receiver view (drives spike_ready, frame bus and tick_overrun)
//
// Optional macro SPIKE_RX_STATS_EN adds frame_count and dup_count.
// -----------------------------------------------------------------------------
interface spike_event_receiver_if #(
    parameter int NUM_NEURONS = 16,
    parameter int NEURON_ID_W = 4
);
    logic                   spike_valid;
    logic [NEURON_ID_W-1:0] spike_id;
    logic                   spike_ready;
    logic                   tick;
    logic                   frame_valid;
    logic [NUM_NEURONS-1:0] frame_spikes;
    logic                   frame_ready;
    logic                   tick_overrun;
`ifdef SPIKE_RX_STATS_EN
    logic [NEURON_ID_W:0]   frame_count;
    logic [7:0]             dup_count;

    modport master (
        output spike_valid, spike_id, tick, frame_ready,
        input  spike_ready, frame_valid, frame_spikes, tick_overrun,
        input  frame_count, dup_count
    );

    modport slave (
        input  spike_valid, spike_id, tick, frame_ready,
        output spike_ready, frame_valid, frame_spikes, tick_overrun,
        output frame_count, dup_count
    );
`else
    modport master (
        output spike_valid, spike_id, tick, frame_ready,
        input  spike_ready, frame_valid, frame_spikes, tick_overrun
    );

    modport slave (
        input  spike_valid, spike_id, tick, frame_ready,
        output spike_ready, frame_valid, frame_spikes, tick_overrun
    );
`endif
endinterface

// File: rtl/spike_event_receiver.sv
// -----------------------------------------------------------------------------
// spike_event_receiver
//
// Consumer end of the serialized spike-event stream. Incoming neuron IDs are
// buffered in a small FIFO; one entry per cycle is popped, decoded to one-hot
// and ORed into a per-timestep accumulator. On tick the events still owed to
// the closing frame are drained, then the bitmap is published downstream over
// a valid/ready handshake.
//
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   bus    : spike_event_receiver_if.slave
//            spike_valid/spike_id/spike_ready : event stream in
//            tick                             : end-of-timestep marker
//            frame_valid/frame_spikes/frame_ready : bitmap out
//            tick_overrun                     : sticky, tick seen outside ACCUM
//
// Optional macro SPIKE_RX_STATS_EN: adds frame_count (popcount of the
// published bitmap) and dup_count (saturating count of pops whose bit was
// already set in the accumulator).
// -----------------------------------------------------------------------------
module spike_event_receiver #(
    parameter int NUM_NEURONS = 16,
    parameter int NEURON_ID_W = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    spike_event_receiver_if.slave       bus
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        PUBLISH
    } state_t;

    state_t state_q;
    state_t state_d;

    // -------------------------------------------------------------------------
    // Event FIFO: pointers carry one extra wrap bit so full/empty fall out of
    // the pointer difference.
    // -------------------------------------------------------------------------
    logic [NEURON_ID_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       count;
    logic [PTR_W-1:0]       drain_cnt;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == PTR_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    // Ready depends only on registered occupancy, never on spike_valid.
    assign push  = bus.spike_valid && !full;
    assign bus.spike_ready = !full;

    // NOTE: the storage array has no reset; its contents are only observed
    // through pointers that are reset, so clearing it would be wasted logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.spike_id;
        end
    end

    // -------------------------------------------------------------------------
    // Head decode: out-of-range IDs decode to zero so they pop harmlessly.
    // -------------------------------------------------------------------------
    logic [NEURON_ID_W-1:0] head_id;
    logic                   head_in_range;
    logic [NUM_NEURONS-1:0] head_bit;
    logic [NUM_NEURONS-1:0] acc;

    assign head_id       = mem[rd_ptr[ADDR_W-1:0]];
    assign head_in_range = (32'(head_id) < NUM_NEURONS);
    assign head_bit      = head_in_range ? (NUM_NEURONS'(1) << head_id) : '0;

    // -------------------------------------------------------------------------
    // Framing FSM (next-state and strobes)
    // -------------------------------------------------------------------------
    logic frame_valid_q;
    logic load_drain;
    logic drain_dec;
    logic publish;
    logic release_frame;
    logic overrun_set;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        load_drain    = 1'b0;
        drain_dec     = 1'b0;
        publish       = 1'b0;
        release_frame = 1'b0;
        overrun_set   = 1'b0;

        case (state_q)
            ACCUM: begin
                pop = !empty;
                if (bus.tick) begin
                    load_drain = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                overrun_set = bus.tick;
                if (drain_cnt != '0) begin
                    // drain_cnt never exceeds occupancy; !empty is belt and braces.
                    pop       = !empty;
                    drain_dec = !empty;
                end else begin
                    // Frame closed: publish, and skip popping so the next
                    // frame's first event does not land in the cleared acc late.
                    publish = 1'b1;
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                overrun_set = bus.tick;
                pop         = !empty;
                if (frame_valid_q && bus.frame_ready) begin
                    release_frame = 1'b1;
                    state_d       = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    logic [NUM_NEURONS-1:0] frame_spikes_q;
    logic                   tick_overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            drain_cnt      <= '0;
            acc            <= '0;
            frame_valid_q  <= 1'b0;
            frame_spikes_q <= '0;
            tick_overrun_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // An event pushed in the tick cycle is owed to the closing frame.
            if (load_drain) begin
                drain_cnt <= count + PTR_W'(push) - PTR_W'(pop);
            end else if (drain_dec) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            // publish and pop are mutually exclusive by construction.
            if (publish) begin
                acc <= '0;
            end else if (pop) begin
                acc <= acc | head_bit;
            end

            if (publish) begin
                frame_spikes_q <= acc;
                frame_valid_q  <= 1'b1;
            end else if (release_frame) begin
                frame_valid_q  <= 1'b0;
            end

            if (overrun_set) begin
                tick_overrun_q <= 1'b1;
            end
        end
    end

    assign bus.frame_valid  = frame_valid_q;
    assign bus.frame_spikes = frame_spikes_q;
    assign bus.tick_overrun = tick_overrun_q;

`ifdef SPIKE_RX_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics
    // -------------------------------------------------------------------------
    function automatic logic [NEURON_ID_W:0] popcount(input logic [NUM_NEURONS-1:0] v);
        logic [NEURON_ID_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            c = c + (NEURON_ID_W + 1)'(v[i]);
        end
        return c;
    endfunction

    logic [NEURON_ID_W:0] frame_count_q;
    logic [7:0]           dup_count_q;
    logic                 dup_hit;

    assign dup_hit = pop && ((acc & head_bit) != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            dup_count_q   <= '0;
        end else begin
            if (publish) begin
                frame_count_q <= popcount(acc);
            end
            if (dup_hit && (dup_count_q != 8'hFF)) begin
                dup_count_q <= dup_count_q + 8'd1;
            end
        end
    end

    assign bus.frame_count = frame_count_q;
    assign bus.dup_count   = dup_count_q;
`endif

endmodule
